// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer.
// Holds every affected channel low for MIN_ASSERT cycles after the reset source
// goes away, then releases the masked channels lowest index first, RELEASE_GAP
// cycles apart. Sources are POR (rst_i), watchdog (full reset) and a software
// request (partial reset of the channels in sw_mask_i).
module rst_seq_ctrl #(
    parameter int N_CHANNELS  = 4,
    parameter int MIN_ASSERT  = 16,
    parameter int RELEASE_GAP = 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  wdt_i,
    input  logic                  sw_req_i,
    input  logic [N_CHANNELS-1:0] sw_mask_i,
    output logic                  sw_ack_o,
    output logic [N_CHANNELS-1:0] rst_no,
    output logic                  done_o,
    output logic [2:0]            cause_o
);

    localparam int CMAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    // A release fires on the edge that sees the counter at (phase length - 1),
    // so the first release lands exactly MIN_ASSERT edges after E0.
    localparam logic [CW-1:0] STRETCH_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP - 1);

    localparam logic [2:0] CAUSE_POR = 3'b001;
    localparam logic [2:0] CAUSE_SW  = 3'b010;
    localparam logic [2:0] CAUSE_WDT = 3'b100;

    typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [N_CHANNELS-1:0]   mask;
    logic [N_CHANNELS-1:0]   pend;
    logic [N_CHANNELS-1:0]   next_bit;
    logic [N_CHANNELS-1:0]   pend_after;
    logic [CW-1:0]           phase_last;
    logic                    found;
    logic                    sw_accept;

    // Pick the lowest-index channel of the active mask that is still in reset.
    always_comb begin
        pend     = mask & ~rst_no;
        next_bit = '0;
        found    = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (pend[i] && !found) begin
                next_bit[i] = 1'b1;
                found       = 1'b1;
            end
        end
        pend_after = pend & ~next_bit;
        phase_last = (state == STRETCH) ? STRETCH_LAST : GAP_LAST;
        sw_accept  = (state == RUN) && sw_req_i && (|sw_mask_i);
    end

    // Sequencer FSM; every output is registered here. Source priority is
    // rst_i, then wdt_i, then the software request.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= HOLD;
            cnt      <= '0;
            mask     <= '1;
            rst_no   <= '0;
            done_o   <= 1'b0;
            sw_ack_o <= 1'b0;
            cause_o  <= CAUSE_POR;
        end else if (wdt_i) begin
            state    <= HOLD;
            cnt      <= '0;
            mask     <= '1;
            rst_no   <= '0;
            done_o   <= 1'b0;
            sw_ack_o <= 1'b0;
            cause_o  <= CAUSE_WDT;
        end else begin
            sw_ack_o <= 1'b0;
            case (state)
                HOLD: begin
                    // Source already dropped (rst_i and wdt_i low): this edge is E0.
                    rst_no <= '0;
                    cnt    <= '0;
                    state  <= STRETCH;
                end
                STRETCH, RELEASE: begin
                    if (cnt >= phase_last) begin
                        rst_no <= rst_no | next_bit;
                        cnt    <= '0;
                        if (pend_after == '0) begin
                            state  <= RUN;
                            done_o <= 1'b1;
                        end else begin
                            state  <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (sw_accept) begin
                        mask     <= sw_mask_i;
                        rst_no   <= rst_no & ~sw_mask_i;
                        sw_ack_o <= 1'b1;
                        cause_o  <= CAUSE_SW;
                        done_o   <= 1'b0;
                        cnt      <= '0;
                        state    <= STRETCH;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default 4-channel instance plus a
// minimal 1-channel instance with MIN_ASSERT=RELEASE_GAP=1.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1, wdt_i = 1'b0, sw_req_i = 1'b0;
    logic [3:0] sw_mask_i = 4'b0000;
    logic       sw_ack_o, done_o;
    logic [3:0] rst_no;
    logic [2:0] cause_o;

    logic       rst1 = 1'b1, wdt1 = 1'b0, sw_req1 = 1'b0;
    logic [0:0] sw_mask1 = 1'b0;
    logic       sw_ack1, done1;
    logic [0:0] rst1_no;
    logic [2:0] cause1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(.N_CHANNELS(4), .MIN_ASSERT(16), .RELEASE_GAP(8)) dut (
        .clk(clk), .rst_i(rst_i), .wdt_i(wdt_i), .sw_req_i(sw_req_i), .sw_mask_i(sw_mask_i),
        .sw_ack_o(sw_ack_o), .rst_no(rst_no), .done_o(done_o), .cause_o(cause_o)
    );

    rst_seq_ctrl #(.N_CHANNELS(1), .MIN_ASSERT(1), .RELEASE_GAP(1)) dut1 (
        .clk(clk), .rst_i(rst1), .wdt_i(wdt1), .sw_req_i(sw_req1), .sw_mask_i(sw_mask1),
        .sw_ack_o(sw_ack1), .rst_no(rst1_no), .done_o(done1), .cause_o(cause1)
    );

    // One active edge, then settle so inputs change and outputs are sampled mid-cycle.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick(5);
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL rst_rst_no got=%b exp=0000", rst_no); end
        vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done_o); end
        vecs++; if (sw_ack_o !== 1'b0) begin errs++; $display("FAIL rst_ack got=%b exp=0", sw_ack_o); end
        vecs++; if (cause_o !== 3'b001) begin errs++; $display("FAIL rst_cause got=%b exp=001", cause_o); end
    endtask

    // Assumes rst_i was high; the first tick is E0. Ends at E40.
    task automatic test_por_release(input string tag, input logic [2:0] exp_cause);
        rst_i = 1'b0;
        tick(1);
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL %s_e0 got=%b exp=0000", tag, rst_no); end
        tick(15);
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL %s_e15 got=%b exp=0000", tag, rst_no); end
        tick(1);
        vecs++; if (rst_no !== 4'b0001) begin errs++; $display("FAIL %s_e16 got=%b exp=0001", tag, rst_no); end
        tick(7);
        vecs++; if (rst_no !== 4'b0001) begin errs++; $display("FAIL %s_e23 got=%b exp=0001", tag, rst_no); end
        tick(1);
        vecs++; if (rst_no !== 4'b0011) begin errs++; $display("FAIL %s_e24 got=%b exp=0011", tag, rst_no); end
        tick(8);
        vecs++; if (rst_no !== 4'b0111) begin errs++; $display("FAIL %s_e32 got=%b exp=0111", tag, rst_no); end
        tick(7);
        vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL %s_e39_done got=%b exp=0", tag, done_o); end
        tick(1);
        vecs++; if (rst_no !== 4'b1111) begin errs++; $display("FAIL %s_e40 got=%b exp=1111", tag, rst_no); end
        vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL %s_e40_done got=%b exp=1", tag, done_o); end
        vecs++; if (cause_o !== exp_cause) begin errs++; $display("FAIL %s_cause got=%b exp=%b", tag, cause_o, exp_cause); end
    endtask

    task automatic test_sw_partial;
        sw_req_i = 1'b1; sw_mask_i = 4'b1010;
        tick(1);  // S
        sw_req_i = 1'b0; sw_mask_i = 4'b0000;
        vecs++; if (rst_no !== 4'b0101) begin errs++; $display("FAIL sw_s got=%b exp=0101", rst_no); end
        vecs++; if (sw_ack_o !== 1'b1) begin errs++; $display("FAIL sw_ack got=%b exp=1", sw_ack_o); end
        vecs++; if (cause_o !== 3'b010) begin errs++; $display("FAIL sw_cause got=%b exp=010", cause_o); end
        vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL sw_done_s got=%b exp=0", done_o); end
        tick(1);
        vecs++; if (sw_ack_o !== 1'b0) begin errs++; $display("FAIL sw_ack_pulse got=%b exp=0", sw_ack_o); end
        tick(14);
        vecs++; if (rst_no !== 4'b0101) begin errs++; $display("FAIL sw_s15 got=%b exp=0101", rst_no); end
        tick(1);
        vecs++; if (rst_no !== 4'b0111) begin errs++; $display("FAIL sw_s16 got=%b exp=0111", rst_no); end
        tick(7);
        vecs++; if (rst_no !== 4'b0111 || done_o !== 1'b0) begin errs++; $display("FAIL sw_s23 got=%b/%b exp=0111/0", rst_no, done_o); end
        tick(1);
        vecs++; if (rst_no !== 4'b1111 || done_o !== 1'b1) begin errs++; $display("FAIL sw_s24 got=%b/%b exp=1111/1", rst_no, done_o); end
        vecs++; if (cause_o !== 3'b010) begin errs++; $display("FAIL sw_cause_hold got=%b exp=010", cause_o); end
    endtask

    task automatic test_wdt_mid_release;
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        tick(1);   // E0
        tick(27);  // E27
        vecs++; if (rst_no !== 4'b0011) begin errs++; $display("FAIL wdt_pre got=%b exp=0011", rst_no); end
        wdt_i = 1'b1;
        tick(1);   // E28 samples wdt
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL wdt_hit got=%b exp=0000", rst_no); end
        vecs++; if (cause_o !== 3'b100) begin errs++; $display("FAIL wdt_cause got=%b exp=100", cause_o); end
        vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL wdt_done got=%b exp=0", done_o); end
        tick(2);
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL wdt_hold got=%b exp=0000", rst_no); end
        wdt_i = 1'b0;
        rst_i = 1'b0;
        test_por_release("wdt", 3'b100);
    endtask

    task automatic test_rejects;
        // zero mask in RUN
        sw_req_i = 1'b1; sw_mask_i = 4'b0000;
        tick(1);
        sw_req_i = 1'b0;
        vecs++; if (sw_ack_o !== 1'b0) begin errs++; $display("FAIL rej_zero_ack got=%b exp=0", sw_ack_o); end
        vecs++; if (rst_no !== 4'b1111 || done_o !== 1'b1) begin errs++; $display("FAIL rej_zero_rst got=%b/%b exp=1111/1", rst_no, done_o); end
        // request together with watchdog
        sw_req_i = 1'b1; sw_mask_i = 4'b1111; wdt_i = 1'b1;
        tick(1);
        sw_req_i = 1'b0; sw_mask_i = 4'b0000; wdt_i = 1'b0;
        vecs++; if (sw_ack_o !== 1'b0) begin errs++; $display("FAIL rej_wdt_ack got=%b exp=0", sw_ack_o); end
        vecs++; if (cause_o !== 3'b100 || rst_no !== 4'b0000) begin errs++; $display("FAIL rej_wdt_path got=%b/%b exp=100/0000", cause_o, rst_no); end
        tick(1);   // E0, now STRETCH
        sw_req_i = 1'b1; sw_mask_i = 4'b0001;
        tick(1);   // E1
        sw_req_i = 1'b0; sw_mask_i = 4'b0000;
        vecs++; if (sw_ack_o !== 1'b0) begin errs++; $display("FAIL rej_stretch_ack got=%b exp=0", sw_ack_o); end
        tick(14);  // E15
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL rej_stretch_e15 got=%b exp=0000", rst_no); end
        tick(1);
        vecs++; if (rst_no !== 4'b0001) begin errs++; $display("FAIL rej_stretch_e16 got=%b exp=0001", rst_no); end
        tick(24);
        vecs++; if (rst_no !== 4'b1111 || done_o !== 1'b1) begin errs++; $display("FAIL rej_stretch_e40 got=%b/%b exp=1111/1", rst_no, done_o); end
        vecs++; if (cause_o !== 3'b100) begin errs++; $display("FAIL rej_stretch_cause got=%b exp=100", cause_o); end
    endtask

    task automatic test_rst_mid_sw;
        sw_req_i = 1'b1; sw_mask_i = 4'b0110;
        tick(1);   // S
        sw_req_i = 1'b0; sw_mask_i = 4'b0000;
        vecs++; if (rst_no !== 4'b1001 || sw_ack_o !== 1'b1) begin errs++; $display("FAIL rmid_s got=%b/%b exp=1001/1", rst_no, sw_ack_o); end
        tick(9);
        rst_i = 1'b1;
        tick(1);   // S+10
        vecs++; if (rst_no !== 4'b0000) begin errs++; $display("FAIL rmid_rst got=%b exp=0000", rst_no); end
        vecs++; if (done_o !== 1'b0 || cause_o !== 3'b001) begin errs++; $display("FAIL rmid_state got=%b/%b exp=0/001", done_o, cause_o); end
        test_por_release("rmid", 3'b001);
    endtask

    task automatic test_min_params;
        rst1 = 1'b1;
        tick(2);
        vecs++; if (rst1_no !== 1'b0 || done1 !== 1'b0 || cause1 !== 3'b001) begin errs++; $display("FAIL min_rst got=%b/%b/%b exp=0/0/001", rst1_no, done1, cause1); end
        rst1 = 1'b0;
        tick(1);   // E0
        vecs++; if (rst1_no !== 1'b0) begin errs++; $display("FAIL min_e0 got=%b exp=0", rst1_no); end
        tick(1);   // E1
        vecs++; if (rst1_no !== 1'b1 || done1 !== 1'b1) begin errs++; $display("FAIL min_e1 got=%b/%b exp=1/1", rst1_no, done1); end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            vecs++; if (rst1_no !== 1'b1 || done1 !== 1'b1) begin errs++; $display("FAIL min_hold%0d got=%b/%b exp=1/1", i, rst1_no, done1); end
        end
        sw_req1 = 1'b1; sw_mask1 = 1'b1;
        tick(1);
        sw_req1 = 1'b0; sw_mask1 = 1'b0;
        vecs++; if (rst1_no !== 1'b0 || sw_ack1 !== 1'b1 || cause1 !== 3'b010) begin errs++; $display("FAIL min_sw got=%b/%b/%b exp=0/1/010", rst1_no, sw_ack1, cause1); end
        tick(1);
        vecs++; if (rst1_no !== 1'b1 || done1 !== 1'b1 || sw_ack1 !== 1'b0) begin errs++; $display("FAIL min_sw_rel got=%b/%b/%b exp=1/1/0", rst1_no, done1, sw_ack1); end
    endtask

    initial begin
        #1;
        test_reset;
        test_por_release("por", 3'b001);
        test_sw_partial;
        test_rejects;
        test_wdt_mid_release;
        test_rst_mid_sw;
        test_min_params;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
